mcd_mul_arb: RTL and testbench
==============================

// Module: mcd_mul_arb
// PURPOSE
//  Shared multiply/scale engine for the MCD sound DSP: time-multiplexes one signed
//  18x8 multiplier among N filter requesters (PCM lo-pass L/R, CDDA hi-pass L/R).
//  Computes res = (a*b)/2^sh with Verilog signed-'/' semantics (truncate toward zero).
//  Sits between the filter state machines and the mixer; replaces per-state multipliers.
// PARAMETERS
//  N_REQ  4   number of requesters (2..8)
//  A_W    18  signed operand a width
//  B_W    8   unsigned operand b width (alpha/gain)
//  SH_W   4   shift-select width; divisor = 2^sh, sh = 0..15
// PORTS
//  clk      in   1              system clock; all state changes on falling edge (negedge clk)
//  rst      in   1              asynchronous, active-low reset
//  req      in   N_REQ          per-requester request level; held until own ack
//  a_flat   in   N_REQ*A_W      signed a, slice i = requester i; stable while req[i]=1
//  b_flat   in   N_REQ*B_W      unsigned b, slice i
//  sh_flat  in   N_REQ*SH_W     shift select, slice i
//  ack      out  N_REQ          one-cycle pulse: res/res_sat valid for that requester
//  res      out  A_W+B_W+1      signed scaled product (27 bits at defaults)
//  res_sat  out  16             res clamped to -32768..32767
//  busy     out  1              any pipeline stage valid
// BEHAVIOUR
//  - Reset (async, rst=0): ack=0, res=0, res_sat=0, busy=0, pending=0, rr pointer=0;
//    all pipeline valid bits cleared; in-flight ops dropped, no ack ever issued for them.
//  - Eligible[i] = req[i] & ~pending[i]. Round-robin: grant lowest i >= ptr among
//    eligible, wrapping; ptr <= granted+1 (mod N_REQ). At most one grant per cycle.
//  - Grant cycle G: latch a,b,sh,id into S1; set pending[id]. No requests -> ptr holds.
//  - S1->S2 (G+1): p = $signed(a)*$signed({1'b0,b}), full width, no overflow possible.
//  - S2->S3 (G+2): q = p/2^sh toward zero: if p<0 add (2^sh-1) before arith >>>.
//  - G+3: ack[id]=1 for one cycle, res=q, res_sat=clamp16(q); pending[id] cleared same
//    cycle. Latency grant->ack = 3 cycles; throughput 1 op/cycle across requesters.
//  - Requester sees ack, then may drop req or keep it high for a new op; a held req is
//    re-eligible the cycle after ack (earliest re-grant G+4 for same id).
//  - req[i] dropped before grant: request withdrawn, nothing happens. Dropped after grant:
//    op completes, ack still pulses (requester ignores).
//  - res/res_sat hold last value when ack=0.
//  - Simultaneous ack of one op and grant of another: both proceed, independent stages.
//  - sh=0: res = p exactly. b=0: res=0. a=-2^(A_W-1), b=255: no overflow in res.
//  - busy = S1.v | S2.v | S3.v.
// STRUCTURE
//  - mcd_dsp_pkg: A_W/B_W/SH_W/RES_W constants, clamp16 function, op struct {a,b,sh,id}.
//  - Sub-module mcd_rr_arb (eligible vector + ptr -> one-hot grant, id, ptr_next).
//  - Top: 3-stage op pipeline with valid bits, pending register, ack decode.
// TESTING
//  1 Single: req0, a=1000,b=128,sh=7 -> grant, ack[0] 3 cycles later, res=1000, res_sat=1000.
//  2 Toward zero: a=-3,b=1,sh=1 -> res=-1 (not -2); a=3,b=1,sh=1 -> res=1.
//  3 Saturate: a=131071,b=255,sh=0 -> res=33423105, res_sat=32767; a=-131072,b=255 ->
//    res=-33423360, res_sat=-32768.
//  4 Contention: req=4'b1111 same cycle, ptr=0 -> grants 0,1,2,3 on consecutive cycles,
//    acks 0,1,2,3 on cycles +3..+6; req0 held -> next grant order wraps to 0 after 3.
//  5 Fairness: req0 held continuously, req2 raised -> req2 granted before req0's 2nd grant.
//  6 Reset mid-op: assert rst=0 with 3 ops in flight -> ack stays 0, busy=0 immediately;
//    after release with req held -> fresh grant starting from requester 0.

Source files
------------

// File: rtl/mcd_mul_arb_pkg.sv
// Shared constants, operation record and saturation helper for the MCD sound DSP
// multiply/scale engine.
package mcd_mul_arb_pkg;

  localparam int unsigned A_W   = 18;
  localparam int unsigned B_W   = 8;
  localparam int unsigned SH_W  = 4;
  localparam int unsigned RES_W = A_W + B_W + 1;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned SAT_W = 16;

  localparam logic signed [RES_W-1:0] SAT_HI = RES_W'(32'sd32767);
  localparam logic signed [RES_W-1:0] SAT_LO = RES_W'(-32'sd32768);

  typedef struct packed {
    logic signed [A_W-1:0] a;
    logic [B_W-1:0]        b;
    logic [SH_W-1:0]       sh;
    logic [ID_W-1:0]       id;
  } op_t;

  function automatic logic signed [SAT_W-1:0] clamp16(input logic signed [RES_W-1:0] v);
    logic signed [SAT_W-1:0] r;
    if (v > SAT_HI) begin
      r = 16'sh7fff;
    end else if (v < SAT_LO) begin
      r = 16'sh8000;
    end else begin
      r = v[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mcd_mul_arb_if.sv
// Requester-side bus of the shared multiply/scale engine: flattened per-requester
// operands in, per-requester ack plus shared result out.
interface mcd_mul_arb_if #(
  parameter int unsigned N_REQ = 4
);
  import mcd_mul_arb_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*A_W-1:0]    a_flat;
  logic [N_REQ*B_W-1:0]    b_flat;
  logic [N_REQ*SH_W-1:0]   sh_flat;
  logic [N_REQ-1:0]        ack;
  logic signed [RES_W-1:0] res;
  logic signed [SAT_W-1:0] res_sat;
  logic                    busy;

  modport master (
    output req, a_flat, b_flat, sh_flat,
    input  ack, res, res_sat, busy
  );

  modport slave (
    input  req, a_flat, b_flat, sh_flat,
    output ack, res, res_sat, busy
  );

endinterface

// File: rtl/mcd_mul_arb_rr_arb.sv
// Round-robin arbiter: picks the lowest eligible index at or above ptr, wrapping,
// and returns one-hot grant, its index and the pointer to use next.
module mcd_rr_arb
  import mcd_mul_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic [ID_W-1:0]  ptr_next
);

  // Pass 0 scans indices >= ptr, pass 1 the wrapped indices below ptr.
  always_comb begin
    grant    = '0;
    gnt_id   = '0;
    gnt_vld  = 1'b0;
    ptr_next = ptr;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!gnt_vld && eligible[i] && ((pass == 0) == (ID_W'(i) >= ptr))) begin
          gnt_vld  = 1'b1;
          grant[i] = 1'b1;
          gnt_id   = ID_W'(i);
          ptr_next = (i + 1 == N_REQ) ? '0 : ID_W'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/mcd_mul_arb.sv
// Shared signed 18x8 multiply / power-of-two scale engine, time-multiplexed among
// N_REQ filter requesters through a 3-stage pipeline clocked on the falling edge.
module mcd_mul_arb
  import mcd_mul_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input logic          clk,
  input logic          rst,
  mcd_mul_arb_if.slave bus
);

  logic [N_REQ-1:0] eligible, grant;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [ID_W-1:0]  ptr_q, ptr_d, ptr_next, gnt_id;
  logic             gnt_vld;

  logic             s1_v_q, s1_v_d;
  op_t              s1_op_q, s1_op_d;

  logic                    s2_v_q, s2_v_d;
  logic signed [RES_W-1:0] s2_p_q, s2_p_d;
  logic [SH_W-1:0]         s2_sh_q, s2_sh_d;
  logic [ID_W-1:0]         s2_id_q, s2_id_d;

  logic                    s3_v_q, s3_v_d;
  logic signed [RES_W-1:0] s3_q_q, s3_q_d;
  logic [ID_W-1:0]         s3_id_q, s3_id_d;

  logic signed [RES_W-1:0] res_q, res_d;
  logic signed [SAT_W-1:0] sat_q, sat_d;

  logic signed [RES_W-1:0] mul_a, mul_b, bias, biased;

  assign eligible = bus.req & ~pending_q;

  mcd_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .gnt_id   (gnt_id),
    .gnt_vld  (gnt_vld),
    .ptr_next (ptr_next)
  );

  // Grant stage: capture the winner's operands.
  always_comb begin
    s1_v_d     = gnt_vld;
    s1_op_d    = s1_op_q;
    ptr_d      = gnt_vld ? ptr_next : ptr_q;
    if (gnt_vld) begin
      s1_op_d.id = gnt_id;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          s1_op_d.a  = bus.a_flat[i*A_W +: A_W];
          s1_op_d.b  = bus.b_flat[i*B_W +: B_W];
          s1_op_d.sh = bus.sh_flat[i*SH_W +: SH_W];
        end
      end
    end
  end

  // Multiply: b is zero-extended so the product is a signed x non-negative value.
  always_comb begin
    mul_a   = {{(RES_W-A_W){s1_op_q.a[A_W-1]}}, s1_op_q.a};
    mul_b   = {{(RES_W-B_W){1'b0}}, s1_op_q.b};
    s2_v_d  = s1_v_q;
    s2_p_d  = mul_a * mul_b;
    s2_sh_d = s1_op_q.sh;
    s2_id_d = s1_op_q.id;
  end

  // Scale: biasing negatives by 2^sh-1 makes the arithmetic shift truncate toward zero.
  always_comb begin
    bias    = (RES_W'(1) << s2_sh_q) - RES_W'(1);
    biased  = s2_p_q + (s2_p_q[RES_W-1] ? bias : '0);
    s3_v_d  = s2_v_q;
    s3_q_d  = biased >>> s2_sh_q;
    s3_id_d = s2_id_q;
  end

  always_comb begin
    ack_d = '0;
    res_d = res_q;
    sat_d = sat_q;
    if (s3_v_q) begin
      res_d = s3_q_q;
      sat_d = clamp16(s3_q_q);
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (s3_id_q == ID_W'(i)) begin
          ack_d[i] = 1'b1;
        end
      end
    end
    pending_d = (pending_q & ~ack_d) | grant;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      ptr_q     <= '0;
      ack_q     <= '0;
      res_q     <= '0;
      sat_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_op_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_p_q    <= '0;
      s2_sh_q   <= '0;
      s2_id_q   <= '0;
      s3_v_q    <= 1'b0;
      s3_q_q    <= '0;
      s3_id_q   <= '0;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      res_q     <= res_d;
      sat_q     <= sat_d;
      s1_v_q    <= s1_v_d;
      s1_op_q   <= s1_op_d;
      s2_v_q    <= s2_v_d;
      s2_p_q    <= s2_p_d;
      s2_sh_q   <= s2_sh_d;
      s2_id_q   <= s2_id_d;
      s3_v_q    <= s3_v_d;
      s3_q_q    <= s3_q_d;
      s3_id_q   <= s3_id_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.res     = res_q;
  assign bus.res_sat = sat_q;
  assign bus.busy    = s1_v_q | s2_v_q | s3_v_q;

endmodule

// File: tb/tb_mcd_mul_arb.sv
// Scoreboard bench for mcd_mul_arb: expected results are queued per issued op and
// matched against acks; ack order and timing are checked for arbitration scenarios.
module tb_mcd_mul_arb;
  import mcd_mul_arb_pkg::*;

  localparam int NR = 4;

  typedef struct {
    int     id;
    longint res;
    longint sat;
  } exp_t;

  logic clk;
  logic rst;

  mcd_mul_arb_if #(.N_REQ(NR)) bus ();

  mcd_mul_arb #(.N_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     vecs = 0;
  int     errs = 0;
  int     cyc  = 0;
  exp_t   sb[$];
  int     ack_id[$];
  int     ack_cy[$];
  bit     reload_v[NR];
  int     rl_a[NR], rl_b[NR], rl_sh[NR];
  int     e_id[8], e_off[8];
  int     base;
  int     left;

  task automatic chk(input string tag, input longint got, input longint want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic longint mdl_res(input int a, input int b, input int sh);
    longint p;
    p = longint'(a) * longint'(b);
    return p / (longint'(1) << sh);
  endfunction

  function automatic longint mdl_sat(input longint r);
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  task automatic issue(input int id, input int a, input int b, input int sh);
    exp_t e;
    bus.req[id] = 1'b1;
    bus.a_flat[id*A_W +: A_W]    = A_W'(a);
    bus.b_flat[id*B_W +: B_W]    = B_W'(b);
    bus.sh_flat[id*SH_W +: SH_W] = SH_W'(sh);
    e.id  = id;
    e.res = mdl_res(a, b, sh);
    e.sat = mdl_sat(e.res);
    sb.push_back(e);
  endtask

  task automatic tick();
    logic [NR-1:0] ak;
    int k;
    @(posedge clk);
    cyc++;
    ak = bus.ack;
    if (ak != '0) chk("ack_onehot", longint'($countones(ak)), 1);
    for (int i = 0; i < NR; i++) begin
      if (ak[i]) begin
        k = -1;
        for (int j = 0; j < sb.size(); j++) if (k < 0 && sb[j].id == i) k = j;
        if (k < 0) begin
          chk("orphan_ack_id", i, -1);
        end else begin
          chk("res", longint'(bus.res), sb[k].res);
          chk("res_sat", longint'(bus.res_sat), sb[k].sat);
          sb.delete(k);
        end
        ack_id.push_back(i);
        ack_cy.push_back(cyc);
        if (reload_v[i]) begin
          reload_v[i] = 1'b0;
          issue(i, rl_a[i], rl_b[i], rl_sh[i]);
        end else begin
          bus.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_order(input string tag, input int n);
    chk({tag, "_nacks"}, ack_id.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < ack_id.size()) begin
        chk({tag, "_id"}, ack_id[i], e_id[i]);
        chk({tag, "_cyc"}, ack_cy[i] - base, e_off[i]);
      end
    end
  endtask

  task automatic new_test();
    ack_id.delete();
    ack_cy.delete();
    base = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    bus.req     = '0;
    bus.a_flat  = '0;
    bus.b_flat  = '0;
    bus.sh_flat = '0;
    for (int i = 0; i < NR; i++) reload_v[i] = 1'b0;

    // Reset state
    run(2);
    chk("rst_ack", longint'(bus.ack), 0);
    chk("rst_res", longint'(bus.res), 0);
    chk("rst_sat", longint'(bus.res_sat), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    rst = 1'b1;
    run(2);

    // Contention from ptr=0, requester 0 re-issues on its ack
    new_test();
    issue(0, 100, 2, 0);
    issue(1, -100, 3, 1);
    issue(2, 7, 9, 2);
    issue(3, -5, 5, 3);
    reload_v[0] = 1'b1; rl_a[0] = 55; rl_b[0] = 4; rl_sh[0] = 1;
    run(12);
    e_id  = '{0, 1, 2, 3, 0, 0, 0, 0};
    e_off = '{4, 5, 6, 7, 8, 0, 0, 0};
    chk_order("t4", 5);
    chk("t4_drain", sb.size(), 0);

    // Fairness: requester 2 competes with re-issuing requester 0 while ptr=1
    new_test();
    issue(0, 11, 11, 0);
    reload_v[0] = 1'b1; rl_a[0] = 22; rl_b[0] = 2; rl_sh[0] = 0;
    run(4);
    issue(2, 33, 3, 0);
    run(8);
    e_id  = '{0, 2, 0, 0, 0, 0, 0, 0};
    e_off = '{4, 8, 9, 0, 0, 0, 0, 0};
    chk_order("t5", 3);
    chk("t5_drain", sb.size(), 0);

    // Single op latency, busy and hold
    new_test();
    issue(0, 1000, 128, 7);
    tick();
    chk("t1_busy", longint'(bus.busy), 1);
    run(7);
    e_id  = '{0, 0, 0, 0, 0, 0, 0, 0};
    e_off = '{4, 0, 0, 0, 0, 0, 0, 0};
    chk_order("t1", 1);
    chk("t1_idle", longint'(bus.busy), 0);
    chk("t1_res_hold", longint'(bus.res), 1000);
    chk("t1_sat_hold", longint'(bus.res_sat), 1000);
    chk("t1_drain", sb.size(), 0);

    // Rounding toward zero, sh=0, b=0
    new_test();
    issue(0, -3, 1, 1);
    issue(1, 3, 1, 1);
    issue(2, 12345, 0, 5);
    issue(3, -7, 3, 0);
    run(10);
    chk("t2_nacks", ack_id.size(), 4);
    chk("t2_drain", sb.size(), 0);

    // Withdrawn request: nothing may happen
    new_test();
    bus.req[3] = 1'b1;
    #2 bus.req[3] = 1'b0;
    run(6);
    chk("wd_nacks", ack_id.size(), 0);

    // Saturation at both extremes
    new_test();
    issue(1, 131071, 255, 0);
    issue(2, -131072, 255, 0);
    run(8);
    chk("t3_nacks", ack_id.size(), 2);
    chk("t3_drain", sb.size(), 0);

    // Random ops across all requesters
    new_test();
    left = 24;
    for (int c = 0; c < 400 && (left > 0 || sb.size() != 0); c++) begin
      for (int i = 0; i < NR; i++) begin
        if (left > 0 && !bus.req[i] && $urandom_range(0, 1) == 1) begin
          issue(i, int'($urandom_range(0, 262143)) - 131072,
                int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
          left--;
        end
      end
      tick();
    end
    chk("rnd_nacks", ack_id.size(), 24);
    chk("rnd_drain", sb.size(), 0);
    run(4);

    // Reset with three ops in flight, then fresh grants from requester 0
    new_test();
    issue(0, 1, 1, 0);
    issue(1, 2, 1, 0);
    issue(2, 3, 1, 0);
    run(3);
    rst = 1'b0;
    #1;
    chk("t6_busy", longint'(bus.busy), 0);
    chk("t6_ack", longint'(bus.ack), 0);
    sb.delete();
    run(2);
    rst = 1'b1;
    new_test();
    issue(0, -200, 17, 2);
    issue(1, 300, 200, 4);
    issue(2, -131072, 1, 15);
    issue(3, 4095, 255, 9);
    run(10);
    e_id  = '{0, 1, 2, 3, 0, 0, 0, 0};
    e_off = '{4, 5, 6, 7, 0, 0, 0, 0};
    chk_order("t6", 4);
    chk("t6_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
